// File: rtl/oc8051_op_prefetch_if.sv
// Bundles the prefetch queue's cxrom-facing and decode-facing signals.
interface oc8051_op_prefetch_if;
    // Decode / control side
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        pop;
    logic [1:0]  pop_len;
    logic [7:0]  inst0;
    logic [7:0]  inst1;
    logic [7:0]  inst2;
    logic [15:0] inst_pc;
    logic [3:0]  count;
    logic        oob;
    logic        pop_err;

    // cxrom side
    logic [15:0] pc1;
    logic [15:0] pc2;
    logic        op_valid;
    logic [7:0]  op0_in;
    logic [7:0]  op1_in;
    logic [7:0]  op2_in;

    // Prefetch queue
    modport slave (
        input  redirect, redirect_pc, pop, pop_len, op_valid, op0_in, op1_in, op2_in,
        output pc1, pc2, inst0, inst1, inst2, inst_pc, count, oob, pop_err
    );

    // Environment driving the queue (decoder plus cxrom)
    modport master (
        output redirect, redirect_pc, pop, pop_len, op_valid, op0_in, op1_in, op2_in,
        input  pc1, pc2, inst0, inst1, inst2, inst_pc, count, oob, pop_err
    );
endinterface

// File: rtl/oc8051_op_prefetch.sv
// Instruction-byte prefetch queue fed three bytes per cycle by the cxrom window.
// The decoder sees up to three head bytes combinationally and pops 1..3 per instruction.
module oc8051_op_prefetch #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rst,
    oc8051_op_prefetch_if.slave  bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    // A push needs three free slots, judged on the pre-edge count
    localparam logic [CntW-1:0] PushMax = CntW'(DEPTH - 3);

    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [15:0]     fetch_pc_q, fetch_pc_d;
    logic [15:0]     head_pc_q, head_pc_d;
    logic            oob_q, oob_d;
    logic            pop_err_q, pop_err_d;

    logic            has_room;
    logic            do_push;
    logic            pop_legal;
    logic [CntW-1:0] pop_len_ext;
    logic [PtrW-1:0] rd_ptr_p1, rd_ptr_p2;
    logic [PtrW-1:0] wr_ptr_p1, wr_ptr_p2;

    assign rd_ptr_p1   = rd_ptr_q + PtrW'(1);
    assign rd_ptr_p2   = rd_ptr_q + PtrW'(2);
    assign wr_ptr_p1   = wr_ptr_q + PtrW'(1);
    assign wr_ptr_p2   = wr_ptr_q + PtrW'(2);
    assign pop_len_ext = CntW'(bus.pop_len);

    assign has_room  = (count_q <= PushMax);
    assign do_push   = !bus.redirect && bus.op_valid && has_room;
    assign pop_legal = bus.pop && (bus.pop_len != 2'd0) && (pop_len_ext <= count_q);

    // Head window and fetch addresses, all straight from registers
    always_comb begin
        bus.pc1     = fetch_pc_q;
        bus.pc2     = fetch_pc_q + 16'd3;
        bus.inst_pc = head_pc_q;
        bus.count   = 4'(count_q);
        bus.oob     = oob_q;
        bus.pop_err = pop_err_q;
        bus.inst0   = (count_q >= CntW'(1)) ? mem_q[rd_ptr_q]  : 8'h00;
        bus.inst1   = (count_q >= CntW'(2)) ? mem_q[rd_ptr_p1] : 8'h00;
        bus.inst2   = (count_q >= CntW'(3)) ? mem_q[rd_ptr_p2] : 8'h00;
    end

    // Next-state: redirect wins over push/pop; push and pop otherwise combine freely
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;
        head_pc_d  = head_pc_q;
        oob_d      = oob_q;
        pop_err_d  = 1'b0;

        if (bus.redirect) begin
            // Dropping everything queued: write side snaps back to the read side
            count_d    = '0;
            wr_ptr_d   = rd_ptr_q;
            fetch_pc_d = bus.redirect_pc;
            head_pc_d  = bus.redirect_pc;
            oob_d      = 1'b0;
        end else begin
            if (has_room) begin
                if (bus.op_valid) begin
                    wr_ptr_d   = wr_ptr_q + PtrW'(3);
                    fetch_pc_d = fetch_pc_q + 16'd3;
                    oob_d      = 1'b0;
                end else begin
                    // Window fell outside the ROM image; hold until redirected
                    oob_d = 1'b1;
                end
            end

            if (pop_legal) begin
                rd_ptr_d  = rd_ptr_q + PtrW'(bus.pop_len);
                head_pc_d = head_pc_q + 16'(bus.pop_len);
            end else if (bus.pop) begin
                pop_err_d = 1'b1;
            end

            count_d = count_q + (do_push ? CntW'(3) : '0) - (pop_legal ? pop_len_ext : '0);
        end
    end

    // Byte array write port; contents need no reset
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (do_push) begin
            mem_d[wr_ptr_q]  = bus.op0_in;
            mem_d[wr_ptr_p1] = bus.op1_in;
            mem_d[wr_ptr_p2] = bus.op2_in;
        end
    end

    // Byte storage
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    // Control state with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            fetch_pc_q <= RESET_PC;
            head_pc_q  <= RESET_PC;
            oob_q      <= 1'b0;
            pop_err_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
            head_pc_q  <= head_pc_d;
            oob_q      <= oob_d;
            pop_err_q  <= pop_err_d;
        end
    end
endmodule
